branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direction predictor built from a table of two-bit saturating counters,
//   indexed either by PC bits alone or by PC bits XOR global history (gshare).
//   Prediction is combinational in decode; training happens when the branch
//   resolves in execute. Global history is updated only at resolution.
//
// Ports
//   clk           : clock, all state changes on its rising edge
//   rst           : asynchronous active-high reset
//   pcD           : PC of the instruction in decode
//   branchD       : decode instruction is a conditional branch
//   pred_takenD   : predicted direction for the decode branch
//   pred_idxD     : table index used for the decode prediction
//   update_en     : a resolved branch is in execute (not stalled / flushed)
//   idxE          : table index carried down with the resolving branch
//   pred_takenE   : prediction carried down with the resolving branch
//   actual_takenE : resolved direction of the branch in execute
//   mispredictE   : resolving branch was mispredicted (drives the flush)
//   ghr           : global history register, newest outcome in bit 0
//   branch_cnt    : saturating count of resolved branches
//   miss_cnt      : saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_W = 6,
    parameter int HIST_W  = 6,
    parameter int GSHARE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pcD,
    input  logic               branchD,
    output logic               pred_takenD,
    output logic [INDEX_W-1:0] pred_idxD,
    input  logic               update_en,
    input  logic [INDEX_W-1:0] idxE,
    input  logic               pred_takenE,
    input  logic               actual_takenE,
    output logic               mispredictE,
    output logic [HIST_W-1:0]  ghr,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    // Next value of a two-bit saturating counter given the resolved direction.
    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    // Increment of a 32-bit statistics counter that sticks at all-ones.
    function automatic logic [31:0] sat32_inc(input logic [31:0] cnt);
        logic [31:0] res;
        if (cnt == 32'hFFFF_FFFF) begin
            res = cnt;
        end else begin
            res = cnt + 32'd1;
        end
        return res;
    endfunction

    logic [1:0]         pht_r [ENTRIES];
    logic [HIST_W-1:0]  ghr_r;
    logic [31:0]        branch_cnt_r;
    logic [31:0]        miss_cnt_r;

    logic [INDEX_W-1:0] pc_idx_s;
    logic [INDEX_W-1:0] hist_ext_s;
    logic [INDEX_W-1:0] pred_idx_s;
    logic [HIST_W:0]    hist_shift_s;
    logic [HIST_W-1:0]  ghr_next_s;
    logic               mispredict_s;
    logic               unused_pc_s;

    // Only the word-index bits of the PC feed the table index.
    assign unused_pc_s = ^{pcD[31:INDEX_W+2], pcD[1:0]};

    // Decode-side index: PC word bits, optionally hashed with zero-extended history.
    always_comb begin
        pc_idx_s               = pcD[INDEX_W+1:2];
        hist_ext_s             = {INDEX_W{1'b0}};
        hist_ext_s[HIST_W-1:0] = ghr_r;
        if (GSHARE != 0) begin
            pred_idx_s = pc_idx_s ^ hist_ext_s;
        end else begin
            pred_idx_s = pc_idx_s;
        end
    end

    // Shift the resolved outcome into history; the extra top bit is simply dropped,
    // which also covers the single-bit history case without a special slice.
    always_comb begin
        hist_shift_s = {ghr_r, actual_takenE};
        ghr_next_s   = hist_shift_s[HIST_W-1:0];
    end

    assign mispredict_s = update_en & (pred_takenE ^ actual_takenE);

    // Prediction reads the stored counter directly: no bypass from a same-cycle update.
    assign pred_idxD   = pred_idx_s;
    assign pred_takenD = branchD & pht_r[pred_idx_s][1];
    assign mispredictE = mispredict_s;

    // Pattern table: reset to weak-not-taken, train the resolving entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (update_en) begin
            pht_r[idxE] <= sat2_next(pht_r[idxE], actual_takenE);
        end
    end

    // History and statistics advance only when a branch resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r        <= {HIST_W{1'b0}};
            branch_cnt_r <= 32'd0;
            miss_cnt_r   <= 32'd0;
        end else if (update_en) begin
            ghr_r        <= ghr_next_s;
            branch_cnt_r <= sat32_inc(branch_cnt_r);
            if (mispredict_s) begin
                miss_cnt_r <= sat32_inc(miss_cnt_r);
            end
        end
    end

    assign ghr        = ghr_r;
    assign branch_cnt = branch_cnt_r;
    assign miss_cnt   = miss_cnt_r;

endmodule
